// File: rtl/ahb_master_pkg.sv
// rtl/ahb_master_pkg.sv - AHB master pipeline constants, types and helpers
package ahb_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;
    localparam logic [2:0] HSIZE_64   = 3'd3;
    localparam logic [2:0] HSIZE_128  = 3'd4;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RESP2    = 2'd1,
        ST_REPLAY_D = 2'd2,
        ST_REPLAY_A = 2'd3
    } state_t;

    // Width-independent part of a transfer; an all-zero record is an empty stage.
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
    } xfer_t;

    function automatic int unsigned bus_lg(input int unsigned wdt);
        return $clog2(wdt / 8);
    endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// rtl/ahb_lane_steer.sv - write-lane replication and read-lane extraction
module ahb_lane_steer
    import ahb_master_pkg::*;
#(
    parameter int WDT = 32,
    localparam int LB = bus_lg(WDT)
) (
    input  logic [WDT-1:0] wdata,
    input  logic [2:0]     wsize,
    input  logic [WDT-1:0] rdata,
    input  logic [LB-1:0]  raddr_lo,
    input  logic [2:0]     rsize,
    output logic [WDT-1:0] wdata_rep,
    output logic [WDT-1:0] rdata_ext
);

    localparam int NB = WDT / 8;

    int unsigned wbytes;
    int unsigned rbytes;
    int unsigned roff;

    always_comb begin
        wbytes    = 32'd1 << wsize;
        rbytes    = 32'd1 << rsize;
        roff      = 32'(raddr_lo) & ~(rbytes - 32'd1);
        wdata_rep = '0;
        rdata_ext = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_rep[i*8 +: 8] = wdata[(32'(i) & (wbytes - 32'd1)) * 8 +: 8];
            if (32'(i) < rbytes) begin
                rdata_ext[i*8 +: 8] = rdata[(roff + 32'(i)) * 8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_master_pipeline_v2.sv
// rtl/ahb_master_pipeline_v2.sv - two-stage AHB master with tagged completions and replay
module ahb_master_pipeline_v2
    import ahb_master_pkg::*;
#(
    parameter int WDT   = 32,
    parameter int TAG_W = 4
) (
    input  logic             i_hclk,
    input  logic             i_hreset_n,
    input  logic             i_hready,
    input  logic             i_hgrant,
    input  logic [1:0]       i_hresp,
    input  logic [WDT-1:0]   i_hrdata,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_write,
    input  logic [31:0]      i_req_addr,
    input  logic [WDT-1:0]   i_req_wdata,
    input  logic [1:0]       i_req_trans,
    input  logic [2:0]       i_req_burst,
    input  logic [2:0]       i_req_size,
    input  logic [3:0]       i_req_prot,
    input  logic             i_req_lock,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic [31:0]      o_haddr,
    output logic [1:0]       o_htrans,
    output logic             o_hwrite,
    output logic [2:0]       o_hsize,
    output logic [2:0]       o_hburst,
    output logic [3:0]       o_hprot,
    output logic             o_hlock,
    output logic             o_hbusreq,
    output logic [WDT-1:0]   o_hwdata,
    output logic             o_cpl_valid,
    output logic             o_cpl_write,
    output logic             o_cpl_err,
    output logic [TAG_W-1:0] o_cpl_tag,
    output logic [WDT-1:0]   o_cpl_rdata
);

    localparam int LB = bus_lg(WDT);

    state_t           state_q, state_nxt;
    xfer_t            a_q, a_nxt, d_q, d_nxt, rd_q, rd_nxt, ra_q, ra_nxt;
    logic [WDT-1:0]   a_wdata_q, a_wdata_nxt, rd_wdata_q, rd_wdata_nxt, ra_wdata_q, ra_wdata_nxt;
    logic [TAG_W-1:0] a_tag_q, a_tag_nxt, d_tag_q, d_tag_nxt;
    logic [TAG_W-1:0] rd_tag_q, rd_tag_nxt, ra_tag_q, ra_tag_nxt;
    logic             ab_valid_q, ab_valid_nxt, ab_write_q, ab_write_nxt;
    logic [TAG_W-1:0] ab_tag_q, ab_tag_nxt;
    logic [1:0]       htrans_q, htrans_nxt;
    logic [WDT-1:0]   hwdata_q, hwdata_nxt;
    logic             hbusreq_q, hbusreq_nxt;
    logic             cpl_valid_q, cpl_valid_nxt, cpl_write_q, cpl_write_nxt, cpl_err_q, cpl_err_nxt;
    logic [TAG_W-1:0] cpl_tag_q, cpl_tag_nxt;
    logic [WDT-1:0]   cpl_rdata_q, cpl_rdata_nxt;
    logic [WDT-1:0]   wrep, rext;
    logic             adv;

    ahb_lane_steer #(.WDT(WDT)) u_steer (
        .wdata     (a_wdata_q),
        .wsize     (a_q.size),
        .rdata     (i_hrdata),
        .raddr_lo  (d_q.addr[LB-1:0]),
        .rsize     (d_q.size),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

    assign adv         = i_hready & i_hgrant;
    assign o_req_ready = adv && (state_q == ST_RUN);

    always_comb begin
        state_nxt     = state_q;
        a_nxt         = a_q;
        a_wdata_nxt   = a_wdata_q;
        a_tag_nxt     = a_tag_q;
        d_nxt         = d_q;
        d_tag_nxt     = d_tag_q;
        rd_nxt        = rd_q;
        rd_wdata_nxt  = rd_wdata_q;
        rd_tag_nxt    = rd_tag_q;
        ra_nxt        = ra_q;
        ra_wdata_nxt  = ra_wdata_q;
        ra_tag_nxt    = ra_tag_q;
        ab_valid_nxt  = 1'b0;
        ab_write_nxt  = ab_write_q;
        ab_tag_nxt    = ab_tag_q;
        htrans_nxt    = htrans_q;
        hwdata_nxt    = hwdata_q;
        cpl_valid_nxt = 1'b0;
        cpl_write_nxt = cpl_write_q;
        cpl_err_nxt   = cpl_err_q;
        cpl_tag_nxt   = cpl_tag_q;
        cpl_rdata_nxt = cpl_rdata_q;

        // The aborted address-phase transfer reports one cycle after the errored one.
        if (ab_valid_q) begin
            cpl_valid_nxt = 1'b1;
            cpl_write_nxt = ab_write_q;
            cpl_err_nxt   = 1'b1;
            cpl_tag_nxt   = ab_tag_q;
            cpl_rdata_nxt = '0;
        end

        unique case (state_q)
            ST_RUN: begin
                if (adv) begin
                    if (d_q.valid) begin
                        cpl_valid_nxt = 1'b1;
                        cpl_write_nxt = d_q.write;
                        cpl_err_nxt   = (i_hresp == HRESP_ERROR);
                        cpl_tag_nxt   = d_tag_q;
                        cpl_rdata_nxt = d_q.write ? '0 : rext;
                    end
                    d_nxt     = a_q;
                    d_tag_nxt = a_tag_q;
                    if (a_q.valid && a_q.write) begin
                        hwdata_nxt = wrep;
                    end
                    if (i_req_valid) begin
                        a_nxt       = '{valid: 1'b1, write: i_req_write, addr: i_req_addr,
                                        trans: i_req_trans, burst: i_req_burst, size: i_req_size,
                                        prot: i_req_prot, lock: i_req_lock};
                        a_wdata_nxt = i_req_wdata;
                        a_tag_nxt   = i_req_tag;
                        htrans_nxt  = i_req_trans;
                    end else begin
                        a_nxt      = '0;
                        htrans_nxt = HTRANS_IDLE;
                    end
                end else if (!i_hready && i_hresp != HRESP_OKAY && d_q.valid) begin
                    state_nxt  = ST_RESP2;
                    htrans_nxt = HTRANS_IDLE;
                end else if (!i_hgrant) begin
                    htrans_nxt = HTRANS_IDLE;
                end
            end
            ST_RESP2: begin
                if (i_hready) begin
                    if (i_hresp == HRESP_RETRY || i_hresp == HRESP_SPLIT) begin
                        rd_nxt       = d_q;
                        rd_wdata_nxt = hwdata_q;
                        rd_tag_nxt   = d_tag_q;
                        ra_nxt       = a_q;
                        ra_wdata_nxt = a_wdata_q;
                        ra_tag_nxt   = a_tag_q;
                        state_nxt    = ST_REPLAY_D;
                    end else begin
                        cpl_valid_nxt = 1'b1;
                        cpl_write_nxt = d_q.write;
                        cpl_err_nxt   = 1'b1;
                        cpl_tag_nxt   = d_tag_q;
                        cpl_rdata_nxt = '0;
                        ab_valid_nxt  = a_q.valid;
                        ab_write_nxt  = a_q.write;
                        ab_tag_nxt    = a_tag_q;
                        state_nxt     = ST_RUN;
                    end
                    a_nxt = '0;
                    d_nxt = '0;
                end
            end
            ST_REPLAY_D: begin
                if (adv) begin
                    d_nxt       = '0;
                    a_nxt       = rd_q;
                    a_nxt.trans = HTRANS_NONSEQ;
                    a_wdata_nxt = rd_wdata_q;
                    a_tag_nxt   = rd_tag_q;
                    htrans_nxt  = HTRANS_NONSEQ;
                    state_nxt   = ra_q.valid ? ST_REPLAY_A : ST_RUN;
                end
            end
            ST_REPLAY_A: begin
                if (adv) begin
                    d_nxt     = a_q;
                    d_tag_nxt = a_tag_q;
                    if (a_q.write) begin
                        hwdata_nxt = wrep;
                    end
                    a_nxt       = ra_q;
                    a_nxt.trans = HTRANS_NONSEQ;
                    a_wdata_nxt = ra_wdata_q;
                    a_tag_nxt   = ra_tag_q;
                    htrans_nxt  = HTRANS_NONSEQ;
                    state_nxt   = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        hbusreq_nxt = a_nxt.valid | d_nxt.valid | ab_valid_nxt | i_req_valid
                    | (state_nxt != ST_RUN);
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q     <= ST_RUN;
            a_q         <= '0;
            a_wdata_q   <= '0;
            a_tag_q     <= '0;
            d_q         <= '0;
            d_tag_q     <= '0;
            rd_q        <= '0;
            rd_wdata_q  <= '0;
            rd_tag_q    <= '0;
            ra_q        <= '0;
            ra_wdata_q  <= '0;
            ra_tag_q    <= '0;
            ab_valid_q  <= 1'b0;
            ab_write_q  <= 1'b0;
            ab_tag_q    <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
            hbusreq_q   <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_write_q <= 1'b0;
            cpl_err_q   <= 1'b0;
            cpl_tag_q   <= '0;
            cpl_rdata_q <= '0;
        end else begin
            state_q     <= state_nxt;
            a_q         <= a_nxt;
            a_wdata_q   <= a_wdata_nxt;
            a_tag_q     <= a_tag_nxt;
            d_q         <= d_nxt;
            d_tag_q     <= d_tag_nxt;
            rd_q        <= rd_nxt;
            rd_wdata_q  <= rd_wdata_nxt;
            rd_tag_q    <= rd_tag_nxt;
            ra_q        <= ra_nxt;
            ra_wdata_q  <= ra_wdata_nxt;
            ra_tag_q    <= ra_tag_nxt;
            ab_valid_q  <= ab_valid_nxt;
            ab_write_q  <= ab_write_nxt;
            ab_tag_q    <= ab_tag_nxt;
            htrans_q    <= htrans_nxt;
            hwdata_q    <= hwdata_nxt;
            hbusreq_q   <= hbusreq_nxt;
            cpl_valid_q <= cpl_valid_nxt;
            cpl_write_q <= cpl_write_nxt;
            cpl_err_q   <= cpl_err_nxt;
            cpl_tag_q   <= cpl_tag_nxt;
            cpl_rdata_q <= cpl_rdata_nxt;
        end
    end

    assign o_haddr     = a_q.addr;
    assign o_htrans    = htrans_q;
    assign o_hwrite    = a_q.write;
    assign o_hsize     = a_q.size;
    assign o_hburst    = a_q.burst;
    assign o_hprot     = a_q.prot;
    assign o_hlock     = a_q.lock;
    assign o_hbusreq   = hbusreq_q;
    assign o_hwdata    = hwdata_q;
    assign o_cpl_valid = cpl_valid_q;
    assign o_cpl_write = cpl_write_q;
    assign o_cpl_err   = cpl_err_q;
    assign o_cpl_tag   = cpl_tag_q;
    assign o_cpl_rdata = cpl_rdata_q;

endmodule
